// File: rtl/cmp_sub_arbiter.sv
// Round-robin arbiter that shares one 64-bit SUB/SLT datapath between NUM_REQ requesters.
// Optional statistics counters (grant_cnt, stall_cnt) are built when CMP_ARB_STATS_EN is defined.
module cmp_sub_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_op,
  input  logic [64*NUM_REQ-1:0]   req_a,
  input  logic [64*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_data,
  output logic                    busy,
`ifdef CMP_ARB_STATS_EN
  output logic [32*NUM_REQ-1:0]   grant_cnt,
  output logic [31:0]             stall_cnt,
`endif
  output logic [1:0]              o_dbg_state
);

  // Handshakes: a request transfers on the rising edge where req_valid[i] & req_ready[i];
  // the response transfers on the rising edge where rsp_valid & rsp_ready. Ready never
  // depends on anything but state, rr_ptr and req_valid.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic            r_op;
  logic [63:0]     r_a;
  logic [63:0]     r_b;
  logic [ID_W-1:0] r_id;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [63:0]     r_rsp_data;

  logic [ID_W-1:0] w_hi_id;
  logic            w_hi_vld;
  logic [ID_W-1:0] w_lo_id;
  logic            w_lo_vld;
  logic [ID_W-1:0] w_grant_id;
  logic            w_grant_vld;
  logic            w_hs;
  logic            w_sel_op;
  logic [63:0]     w_sel_a;
  logic [63:0]     w_sel_b;
  logic [ID_W-1:0] w_rr_next;
  logic [63:0]     w_diff;
  logic            w_ovf;
  logic            w_lt;
  logic [63:0]     w_result;

  // Lowest valid index at or above rr_ptr wins; otherwise lowest valid index below it.
  always_comb begin
    w_hi_id  = '0;
    w_hi_vld = 1'b0;
    w_lo_id  = '0;
    w_lo_vld = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (ID_W'(j) >= r_rr_ptr)) begin
        w_hi_id  = ID_W'(j);
        w_hi_vld = 1'b1;
      end
      if (req_valid[j] && (ID_W'(j) < r_rr_ptr)) begin
        w_lo_id  = ID_W'(j);
        w_lo_vld = 1'b1;
      end
    end
    w_grant_id  = w_hi_vld ? w_hi_id : w_lo_id;
    w_grant_vld = w_hi_vld | w_lo_vld;
  end

  assign w_hs      = w_grant_vld && (r_state == S_IDLE) && rst_n;
  assign w_rr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

  always_comb begin
    req_ready = '0;
    w_sel_op  = 1'b0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = w_hs && (w_grant_id == ID_W'(j));
      if (w_grant_id == ID_W'(j)) begin
        w_sel_op = req_op[j];
        w_sel_a  = req_a[j*64 +: 64];
        w_sel_b  = req_b[j*64 +: 64];
      end
    end
  end

  // Signed compare derived from the subtractor: sign of the difference, flipped on overflow.
  assign w_diff   = r_a - r_b;
  assign w_ovf    = (r_a[63] ^ r_b[63]) & (w_diff[63] ^ r_a[63]);
  assign w_lt     = w_diff[63] ^ w_ovf;
  assign w_result = r_op ? {63'b0, w_lt} : w_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_op        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_op     <= w_sel_op;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_id     <= w_grant_id;
            r_rr_ptr <= w_rr_next;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign busy        = (r_state == S_EXEC) || (r_state == S_RESP);
  assign o_dbg_state = r_state;

`ifdef CMP_ARB_STATS_EN
  logic [32*NUM_REQ-1:0] r_grant_cnt;
  logic [31:0]           r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_ready[j]) begin
          r_grant_cnt[j*32 +: 32] <= r_grant_cnt[j*32 +: 32] + 32'd1;
        end
      end
      if (r_rsp_valid && !rsp_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/cmp_sub_arbiter.md
Name: cmp_sub_arbiter

Overview:
- Shares one 64-bit subtract/set-less-than datapath between NUM_REQ requesters (e.g. execute stage, branch-compare unit).
- Round-robin arbitration, per-requester valid/ready request handshake, single registered response channel with backpressure.
- One operation in flight at a time; the datapath is instantiated once inside the block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 3, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_op  input  NUM_REQ  per-requester op: 0 = SUB (A-B), 1 = SLT.
- req_a  input  64*NUM_REQ  operand A, requester i at bits [64i+63:64i].
- req_b  input  64*NUM_REQ  operand B, same packing.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_data  output  64  result.
- busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset (async assert, sync release): state IDLE; rr_ptr = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; req_ready = 0; busy = 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid set, searching from rr_ptr upward with wrap to 0.
  - req_ready[grant] is driven combinationally high that cycle; all other req_ready bits stay 0.
  - On handshake: latch op, A, B and id; rr_ptr <= grant+1 (wraps NUM_REQ-1 -> 0); go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (one cycle): the shared datapath evaluates the latched operands.
  - SUB: rsp_data = A - B mod 2^64.
  - SLT: rsp_data = {63'b0, lt}, where lt = 1 iff A < B as signed 64-bit two's complement. Overflow is corrected: lt = diff[63] XOR overflow on A-B.
  - Result and id are registered; go to RESP.
- RESP: rsp_valid = 1; rsp_id and rsp_data held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0, return to IDLE.
  - If rsp_ready is already high on RESP entry, exit after one cycle.
- Latency: accept at cycle N -> rsp_valid at N+2. Minimum issue interval 3 cycles. No new req_ready while busy.
- Requests are not dropped: a requester keeps req_valid and its operands stable until granted. The block never samples operands without a handshake.
- Simultaneous requests: round-robin guarantees a requester waits at most NUM_REQ-1 grants.
- Reset mid-operation: the in-flight result is discarded, rsp_valid drops immediately, rr_ptr returns to 0.
- rsp_ready while rsp_valid = 0 is ignored.

Optional Feature:
- Macro CMP_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (32*NUM_REQ bits): one 32-bit counter per requester, incremented on each request handshake, wrapping at 2^32-1 -> 0, reset to 0.
  - Adds output stall_cnt (32 bits): counts cycles with rsp_valid & !rsp_ready, saturating at 2^32-1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle: all outputs 0, req_ready stays 0 with no req_valid.
- Req0 SUB A=5, B=7 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=0xFFFF_FFFF_FFFF_FFFE.
- Req1 SLT A=0x8000_0000_0000_0000, B=1 -> rsp_data=1. Then A=0x7FFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF -> rsp_data=0 (overflow case). A=B=3 -> 0.
- Both requesters valid continuously for 6 ops -> grant order 0,1,0,1,0,1 with rr_ptr wrapping; no req_ready overlap.
- rsp_ready held low 5 cycles in RESP -> rsp_id and rsp_data stable, no new grant. Release -> IDLE next cycle. With CMP_ARB_STATS_EN, stall_cnt=5.
- rst_n asserted during EXEC -> rsp_valid never rises. After release, first grant goes to requester 0.
